// File: rtl/vga_pkg.sv
// Shared definitions for the VGA/drawing-engine SRAM arbiter: frame geometry,
// address width, starvation limit and the access tag carried down the pipeline.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_ADDR_WIDTH   = 19;
  localparam int unsigned DEF_STARVE_LIMIT = 800;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_VGA_RD  = 2'd1,
    TAG_DRAW_RD = 2'd2,
    TAG_BLACK   = 2'd3
  } tag_t;

  // drop marks a draw read that was out of range and must return zero
  typedef struct packed {
    tag_t tag;
    logic drop;
  } stage_t;

endpackage

// File: rtl/vga_pixel_address.sv
// Combinational pixel-coordinate to SRAM word address, plus visible-area check.
module vga_pixel_address
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);

  assign addr     = ADDR_WIDTH'(y) * ADDR_WIDTH'(H_ACTIVE) + ADDR_WIDTH'(x);
  assign in_range = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);

endmodule

// File: rtl/vga_sram_arbiter.sv
// Single-port pixel SRAM arbiter: VGA scan-out always wins, the drawing engine
// takes the remaining cycles; 3-cycle read latency with a tagged return pipe.
module vga_sram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  vga_fetch_i,
  input  logic [9:0]            vga_x_i,
  input  logic [9:0]            vga_y_i,
  output logic [7:0]            red_o,
  output logic [7:0]            green_o,
  output logic [7:0]            blue_o,
  input  logic                  draw_valid_i,
  output logic                  draw_ready_o,
  input  logic                  draw_we_i,
  input  logic [9:0]            draw_x_i,
  input  logic [9:0]            draw_y_i,
  input  logic [23:0]           draw_wdata_i,
  output logic                  draw_rvalid_o,
  output logic [23:0]           draw_rdata_o,
  output logic                  draw_starved_o,
  input  logic                  starve_clear_i,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [23:0]           sram_wdata_o,
  input  logic [23:0]           sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] vga_addr, draw_addr;
  logic                  vga_ok, draw_ok, draw_acc, stall;
  logic                  en_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [23:0]           wdata_d;
  stage_t                s0;
  stage_t [2:1]          pipe;
  logic [CNT_W-1:0]      stall_cnt;

  vga_pixel_address #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_WIDTH(ADDR_WIDTH))
    u_vga_addr (.x(vga_x_i), .y(vga_y_i), .addr(vga_addr), .in_range(vga_ok));

  vga_pixel_address #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_WIDTH(ADDR_WIDTH))
    u_draw_addr (.x(draw_x_i), .y(draw_y_i), .addr(draw_addr), .in_range(draw_ok));

  assign draw_ready_o = ~vga_fetch_i & reset_n_i;
  assign draw_acc     = draw_valid_i & draw_ready_o;
  assign stall        = draw_valid_i & ~draw_ready_o;

  always_comb begin
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    s0      = '{tag: TAG_NONE, drop: 1'b0};
    if (vga_fetch_i) begin
      if (vga_ok) begin
        en_d   = 1'b1;
        addr_d = vga_addr;
        s0.tag = TAG_VGA_RD;
      end else begin
        s0.tag = TAG_BLACK;
      end
    end else if (draw_acc) begin
      if (draw_ok) begin
        en_d   = 1'b1;
        we_d   = draw_we_i;
        addr_d = draw_addr;
        if (draw_we_i) wdata_d = draw_wdata_i;
      end
      // writes finish at the SRAM and ride the pipe as NONE
      if (!draw_we_i) begin
        s0.tag  = TAG_DRAW_RD;
        s0.drop = ~draw_ok;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sram_en_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      pipe         <= '0;
    end else begin
      sram_en_o    <= en_d;
      sram_we_o    <= we_d;
      sram_addr_o  <= addr_d;
      sram_wdata_o <= wdata_d;
      pipe         <= {pipe[1], s0};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      {red_o, green_o, blue_o} <= '0;
      draw_rvalid_o            <= 1'b0;
      draw_rdata_o             <= '0;
    end else begin
      case (pipe[2].tag)
        TAG_VGA_RD: {red_o, green_o, blue_o} <= sram_rdata_i;
        TAG_BLACK:  {red_o, green_o, blue_o} <= '0;
        default: ;
      endcase
      draw_rvalid_o <= (pipe[2].tag == TAG_DRAW_RD);
      if (pipe[2].tag == TAG_DRAW_RD)
        draw_rdata_o <= pipe[2].drop ? 24'h0 : sram_rdata_i;
    end
  end

  // flag is set on the edge that brings the counter to the limit; clear wins
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt      <= '0;
      draw_starved_o <= 1'b0;
    end else if (starve_clear_i) begin
      stall_cnt      <= '0;
      draw_starved_o <= 1'b0;
    end else begin
      if (stall) begin
        if (stall_cnt != CNT_W'(STARVE_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt >= CNT_W'(STARVE_LIMIT - 1)) draw_starved_o <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Scoreboard bench for vga_sram_arbiter: stimulus pushes expectations tagged
// with the cycle they fall due; a negedge monitor pops and compares them.
module tb_vga_sram_arbiter;

  localparam int K_RGB = 0, K_RDATA = 1, K_WR = 2, K_RD = 3,
                 K_NOEN = 4, K_READY = 5, K_STARVED = 6;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    logic [31:0] aux;
  } exp_t;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        vga_fetch;
  logic [9:0]  vga_x, vga_y;
  logic [7:0]  red_o, green_o, blue_o;
  logic        draw_valid, draw_ready_o, draw_we;
  logic [9:0]  draw_x, draw_y;
  logic [23:0] draw_wdata;
  logic        draw_rvalid_o;
  logic [23:0] draw_rdata_o;
  logic        draw_starved_o;
  logic        starve_clear;
  logic        sram_en_o, sram_we_o;
  logic [18:0] sram_addr_o;
  logic [23:0] sram_wdata_o;
  logic [23:0] sram_rdata = '0;

  logic [23:0] mem [int];
  exp_t        sb [$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  vga_sram_arbiter dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .vga_fetch_i(vga_fetch), .vga_x_i(vga_x), .vga_y_i(vga_y),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .draw_valid_i(draw_valid), .draw_ready_o(draw_ready_o), .draw_we_i(draw_we),
    .draw_x_i(draw_x), .draw_y_i(draw_y), .draw_wdata_i(draw_wdata),
    .draw_rvalid_o(draw_rvalid_o), .draw_rdata_o(draw_rdata_o),
    .draw_starved_o(draw_starved_o), .starve_clear_i(starve_clear),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc++;

  // synchronous single-port SRAM, read data one cycle after the address
  always @(posedge clock_i) begin
    if (sram_en_o) begin
      if (sram_we_o) mem[int'(sram_addr_o)] = sram_wdata_o;
      else sram_rdata <= mem.exists(int'(sram_addr_o)) ? mem[int'(sram_addr_o)] : 24'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [31:0] val,
                      input logic [31:0] aux = 32'h0);
    exp_t e;
    e.due = due; e.kind = kind; e.val = val; e.aux = aux;
    sb.push_back(e);
  endtask

  always @(negedge clock_i) begin
    bit saw;
    saw = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_RGB:     check("rgb", {8'h0, red_o, green_o, blue_o}, sb[i].val);
          K_RDATA: begin
            check("draw_rvalid", 32'(draw_rvalid_o), 32'd1);
            check("draw_rdata", 32'(draw_rdata_o), sb[i].val);
            saw = 1'b1;
          end
          K_WR: begin
            check("wr_cmd", 32'({sram_en_o, sram_we_o}), 32'd3);
            check("wr_addr", 32'(sram_addr_o), sb[i].val);
            check("wr_data", 32'(sram_wdata_o), sb[i].aux);
          end
          K_RD: begin
            check("rd_cmd", 32'({sram_en_o, sram_we_o}), 32'd2);
            check("rd_addr", 32'(sram_addr_o), sb[i].val);
          end
          K_NOEN:    check("no_access", 32'(sram_en_o), 32'd0);
          K_READY:   check("draw_ready", 32'(draw_ready_o), sb[i].val);
          K_STARVED: check("starved", 32'(draw_starved_o), sb[i].val);
          default: ;
        endcase
        sb.delete(i);
      end
    end
    if (!saw && draw_rvalid_o) check("spurious_rvalid", 32'(draw_rvalid_o), 32'd0);
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle();
    vga_fetch = 0; draw_valid = 0; draw_we = 0; starve_clear = 0;
  endtask

  // addr < 0 means the coordinate is off-screen
  task automatic do_vga(input int x, input int y, input int addr, input logic [23:0] rgb);
    vga_fetch = 1; draw_valid = 0; vga_x = 10'(x); vga_y = 10'(y);
    if (addr < 0) push(cyc + 1, K_NOEN, 0);
    else          push(cyc + 1, K_RD, 32'(addr));
    push(cyc + 3, K_RGB, {8'h0, rgb});
    tick();
  endtask

  task automatic do_draw(input bit we, input int x, input int y, input logic [23:0] wd,
                         input int addr, input logic [23:0] rexp);
    vga_fetch = 0; draw_valid = 1; draw_we = we;
    draw_x = 10'(x); draw_y = 10'(y); draw_wdata = wd;
    push(cyc, K_READY, 1);
    if (addr < 0)  push(cyc + 1, K_NOEN, 0);
    else if (we)   push(cyc + 1, K_WR, 32'(addr), {8'h0, wd});
    else           push(cyc + 1, K_RD, 32'(addr));
    if (!we) push(cyc + 3, K_RDATA, {8'h0, rexp});
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram"}, 32'({sram_en_o, sram_we_o}), 32'd0);
    check({tag, "_addr"}, 32'(sram_addr_o), 32'd0);
    check({tag, "_wdata"}, 32'(sram_wdata_o), 32'd0);
    check({tag, "_rgb"}, {8'h0, red_o, green_o, blue_o}, 32'd0);
    check({tag, "_rvalid"}, 32'(draw_rvalid_o), 32'd0);
    check({tag, "_rdata"}, 32'(draw_rdata_o), 32'd0);
    check({tag, "_starved"}, 32'(draw_starved_o), 32'd0);
    check({tag, "_ready"}, 32'(draw_ready_o), 32'd0);
  endtask

  initial begin
    int s2;
    reset_n_i = 0; idle();
    vga_x = 0; vga_y = 0; draw_x = 0; draw_y = 0; draw_wdata = 0;
    draw_valid = 1;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n_i = 1; idle();
    tick();

    do_draw(1, 3, 2, 24'hFF0000, 1283, 0);
    do_vga(3, 2, 1283, 24'hFF0000);
    do_draw(1, 10, 0, 24'h123456, 10, 0);
    do_draw(1, 639, 479, 24'hABCDEF, 307199, 0);
    do_draw(1, 0, 480, 24'h777777, -1, 0);
    do_vga(10, 0, 10, 24'h123456);
    do_vga(639, 479, 307199, 24'hABCDEF);
    idle();
    push(cyc + 3, K_RGB, 32'hABCDEF);
    tick();
    do_vga(640, 0, -1, 24'h0);
    do_draw(0, 3, 2, 0, 1283, 24'hFF0000);
    do_draw(0, 700, 0, 0, -1, 24'h0);
    do_draw(1, 5, 5, 24'h0F0F0F, 3205, 0);
    do_draw(0, 5, 5, 0, 3205, 24'h0F0F0F);
    idle();
    repeat (4) tick();

    // VGA and draw both requesting: VGA owns every cycle until it lets go
    draw_valid = 1; draw_we = 0; draw_x = 3; draw_y = 2;
    vga_fetch = 1; vga_x = 10; vga_y = 0;
    for (int i = 0; i < 5; i++) begin
      push(cyc, K_READY, 0);
      push(cyc + 1, K_RD, 32'd10);
      push(cyc + 3, K_RGB, 32'h123456);
      tick();
    end
    vga_fetch = 0;
    push(cyc, K_READY, 1);
    push(cyc + 1, K_RD, 32'd1283);
    push(cyc + 3, K_RDATA, 32'hFF0000);
    tick();
    idle();
    repeat (4) tick();

    // a gap without draw_valid restarts the stall count
    vga_fetch = 1; vga_x = 0; vga_y = 0; draw_valid = 1;
    repeat (500) tick();
    draw_valid = 0;
    tick();
    draw_valid = 1;
    s2 = cyc;
    push(s2, K_STARVED, 0);
    push(s2 + 799, K_STARVED, 0);
    push(s2 + 800, K_STARVED, 1);
    push(s2 + 801, K_STARVED, 1);
    push(s2 + 802, K_STARVED, 0);
    repeat (800) tick();
    idle();
    tick();
    starve_clear = 1;
    tick();
    starve_clear = 0;
    repeat (3) tick();

    // reset in the cycle after a draw read is issued: that read must vanish
    vga_fetch = 0; draw_valid = 1; draw_we = 0; draw_x = 3; draw_y = 2;
    tick();
    reset_n_i = 0; idle();
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    reset_n_i = 1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_rvalid", 32'(draw_rvalid_o), 32'd0);
      tick();
    end

    repeat (4) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sram_arbiter.md
# vga_sram_arbiter

Shares one synchronous single-port pixel SRAM between the VGA scan-out path and a drawing engine. The VGA fetch has absolute priority. The drawing engine gets every other cycle through a valid/ready handshake. The block sits between the VGA timing controller (which supplies pixel coordinates), the drawing engine, and the SRAM. It also flags drawing-engine starvation.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- V_ACTIVE, 480: visible lines
- ADDR_WIDTH, 19: SRAM word address width
- STARVE_LIMIT, 800: consecutive stalled cycles before starvation is flagged

Ports:
- clock_i  in  1  pixel clock; the only clock
- reset_n_i  in  1  asynchronous, active-low reset
- vga_fetch_i  in  1  VGA needs the pixel at (vga_x_i, vga_y_i) this cycle
- vga_x_i  in  10  VGA pixel column
- vga_y_i  in  10  VGA pixel row
- red_o, green_o, blue_o  out  8 each  fetched pixel colour, registered
- draw_valid_i  in  1  drawing request present
- draw_ready_o  out  1  request accepted this cycle if valid
- draw_we_i  in  1  1 = write, 0 = read
- draw_x_i, draw_y_i  in  10 each  target pixel
- draw_wdata_i  in  24  {R,G,B} write data
- draw_rvalid_o  out  1  one-cycle pulse: draw_rdata_o valid
- draw_rdata_o  out  24  read data for the drawing engine
- draw_starved_o  out  1  sticky starvation flag
- starve_clear_i  in  1  clears draw_starved_o and the stall counter
- sram_en_o  out  1  SRAM access this cycle
- sram_we_o  out  1  SRAM write strobe
- sram_addr_o  out  ADDR_WIDTH  word address
- sram_wdata_o  out  24  write data
- sram_rdata_i  in  24  read data, valid the cycle after address

## Operation
- Address is y*H_ACTIVE + x, computed as (y<<9)+(y<<7)+x for the default value, with ADDR_WIDTH-bit result. A coordinate is in range only if x<H_ACTIVE and y<V_ACTIVE.
- Each cycle the arbiter picks one winner:
  - VGA, if vga_fetch_i=1.
  - Otherwise draw, if draw_valid_i=1.
  - Otherwise idle.
- draw_ready_o = ~vga_fetch_i. It is combinational and 0 while reset is asserted.
- Out-of-range VGA fetch: no SRAM access; the pixel output is black.
- Out-of-range draw request: accepted but dropped. A dropped write has no effect. A dropped read returns 0 with draw_rvalid_o on the normal schedule.
- Each issued access carries a 2-bit tag: NONE, VGA_RD, DRAW_RD, or BLACK. The tag travels down a pipeline of 2 stages; stage 1 is aligned with the SRAM command and stage 2 with the SRAM read data.
- Stage-2 tag routing:
  - VGA_RD loads {red_o, green_o, blue_o} from sram_rdata_i.
  - BLACK loads 0 into the RGB outputs.
  - DRAW_RD loads draw_rdata_o and pulses draw_rvalid_o.
  - A DRAW_RD that was dropped as out of range loads 0 instead of SRAM data.
  - NONE, and draw writes, leave the RGB outputs holding their value.
- Starvation counter:
  - Increments each cycle draw_valid_i & ~draw_ready_o, saturating at STARVE_LIMIT.
  - Resets to 0 on any accepted draw or any cycle without draw_valid_i.
  - Reaching STARVE_LIMIT sets draw_starved_o, which stays set until starve_clear_i or reset.
  - If starve_clear_i and the set condition occur in the same cycle, the clear wins.

## Timing
- Cycle t is the arbitration cycle.
- Cycle t+1: sram_en_o, sram_we_o, sram_addr_o and sram_wdata_o are driven from registers.
- Cycle t+2: sram_rdata_i is valid.
- Cycle t+3: RGB outputs or draw_rdata_o/draw_rvalid_o are updated.
- Total read latency is 3 cycles. The VGA controller must therefore lead its coordinates by 3 cycles.
- A write reaches the SRAM in cycle t+1. It needs no further pipeline slot but still occupies the tag pipeline as NONE.
- Back-to-back accesses are allowed with throughput of 1 per cycle. A write followed by a read of the same address returns the new data, because the SRAM sees the write first.
- Reset values:
  - All SRAM outputs are 0.
  - RGB outputs are 0.
  - draw_rvalid_o is 0 and draw_rdata_o is 0.
  - draw_starved_o is 0 and the stall counter is 0.
  - All tags are NONE.
- Reset asserted mid-operation: in-flight reads are discarded and produce no draw_rvalid_o pulse after reset is released.

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE and V_ACTIVE defaults
  - ADDR_WIDTH
  - the 2-bit tag enum (NONE, VGA_RD, DRAW_RD, BLACK)
  - the starvation limit default
- One sub-module, vga_pixel_address, performs the combinational x,y → address computation and range check. It is instantiated twice, once for the VGA path and once for the draw path.

## Test plan
- Reset, then draw write (x=3, y=2, data 0xFF0000) with vga_fetch_i=0 → in cycle t+1, sram_we_o=1 and sram_addr_o=1283.
- Draw write to (3,2), then VGA fetch (3,2) → 3 cycles after the fetch, red_o=0xFF, green_o=0 and blue_o=0.
- Both vga_fetch_i=1 and draw_valid_i=1 for 5 cycles → draw_ready_o=0 throughout and 5 VGA reads are issued. The draw is accepted in the first cycle fetch drops.
- vga_fetch_i held high with draw_valid_i=1 for 800 cycles → draw_starved_o rises after the 800th stalled cycle. A starve_clear_i pulse clears it.
- Draw read at x=700 → no SRAM access, and draw_rvalid_o pulses in cycle t+3 with draw_rdata_o=0.
- Issue a draw read, then assert reset_n_i=0 in cycle t+1 → all outputs are 0, and no draw_rvalid_o pulse follows after reset is released.
